// File: rtl/aes_128_keyexp_sched.sv
// AES-128 key schedule sequencer.
// Steps an external round-key unit and streams 22 halves to key RAM.
module aes_128_keyexp_sched #(
  parameter int unsigned NUM_ROUNDS     = 10,
  parameter int unsigned LENGTH_KEY_SET = 22,
  parameter logic [7:0]  RCON_INIT      = 8'h01
) (
  input  logic         i_clk,
  input  logic         i_kill,
  input  logic [127:0] i_key_in,
  input  logic         i_key_valid,
  output logic         o_key_accept,
  input  logic         i_wr_idle,
  output logic         o_exp_step,
  output logic [127:0] o_exp_key_cur,
  output logic [7:0]   o_exp_rcon,
  input  logic [127:0] i_exp_key_out,
  output logic         o_en_wr,
  output logic [63:0]  o_ram_in,
  output logic         o_busy,
  output logic         o_set_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_LO,
    S_WR_HI,
    S_STEP,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] LP_LAST = 4'(NUM_ROUNDS);

  // A key set must hold exactly one low/high pair per round key.
  if (LENGTH_KEY_SET != 2 * (NUM_ROUNDS + 1)) begin : g_len_chk
    $error("LENGTH_KEY_SET must equal 2*(NUM_ROUNDS+1)");
  end

  state_t       r_state;
  state_t       w_next;
  logic [127:0] r_cur_key;
  logic [7:0]   r_rcon;
  logic [3:0]   r_round_cnt;

  logic         w_accept;
  logic         w_step;
  logic         w_en_wr;
  logic [63:0]  w_ram;
  logic         w_done;
  logic         w_busy;

  function automatic logic [7:0] xtime(input logic [7:0] r);
    xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
  endfunction

  // State register; kill returns to IDLE from anywhere.
  always_ff @(posedge i_clk) begin
    if (i_kill) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Round key, round constant and round counter.
  always_ff @(posedge i_clk) begin
    if (i_kill) begin
      r_cur_key   <= '0;
      r_rcon      <= RCON_INIT;
      r_round_cnt <= '0;
    end else if (w_accept) begin
      r_cur_key   <= i_key_in;
      r_rcon      <= RCON_INIT;
      r_round_cnt <= '0;
    end else if (r_state == S_WAIT) begin
      r_cur_key   <= i_exp_key_out;
      r_rcon      <= xtime(r_rcon);
      r_round_cnt <= r_round_cnt + 4'd1;
    end
  end

  // Next state and per-state strobes.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_step   = 1'b0;
    w_en_wr  = 1'b0;
    w_ram    = '0;
    w_done   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (!i_kill && i_key_valid && !i_wr_idle) begin
          w_accept = 1'b1;
          w_next   = S_WR_LO;
        end
      end
      S_WR_LO: begin
        w_en_wr = 1'b1;
        w_ram   = r_cur_key[63:0];
        w_next  = S_WR_HI;
      end
      S_WR_HI: begin
        w_en_wr = 1'b1;
        w_ram   = r_cur_key[127:64];
        w_next  = (r_round_cnt == LP_LAST) ? S_DONE : S_STEP;
      end
      S_STEP: begin
        w_step = 1'b1;
        w_next = S_WAIT;
      end
      S_WAIT: begin
        w_next = S_WR_LO;
      end
      S_DONE: begin
        w_done = 1'b1;
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Busy covers the accept cycle through DONE.
  always_comb begin
    w_busy = (r_state != S_IDLE) | w_accept;
  end

  assign o_key_accept  = w_accept;
  assign o_exp_step    = w_step;
  assign o_exp_key_cur = r_cur_key;
  assign o_exp_rcon    = r_rcon;
  assign o_en_wr       = w_en_wr;
  assign o_ram_in      = w_ram;
  assign o_busy        = w_busy;
  assign o_set_done    = w_done;

endmodule

// File: tb/tb_aes_128_keyexp_sched.sv
// Directed bench for aes_128_keyexp_sched.
// Includes a model of the external one-round key-expansion unit.
module tb_aes_128_keyexp_sched;

  logic         clk = 1'b0;
  logic         kill;
  logic [127:0] key_in;
  logic         key_valid;
  logic         key_accept;
  logic         wr_idle;
  logic         exp_step;
  logic [127:0] exp_key_cur;
  logic [7:0]   exp_rcon;
  logic [127:0] exp_key_out = '0;
  logic         en_wr;
  logic [63:0]  ram_in;
  logic         busy;
  logic         set_done;

  always #5 clk = ~clk;

  aes_128_keyexp_sched dut (
    .i_clk        (clk),
    .i_kill       (kill),
    .i_key_in     (key_in),
    .i_key_valid  (key_valid),
    .o_key_accept (key_accept),
    .i_wr_idle    (wr_idle),
    .o_exp_step   (exp_step),
    .o_exp_key_cur(exp_key_cur),
    .o_exp_rcon   (exp_rcon),
    .i_exp_key_out(exp_key_out),
    .o_en_wr      (en_wr),
    .o_ram_in     (ram_in),
    .o_busy       (busy),
    .o_set_done   (set_done)
  );

  logic [7:0] sbox [256] = '{
    8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
    8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
    8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
    8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
    8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
    8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
    8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
    8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
    8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
    8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
    8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
    8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
    8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
    8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
    8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
    8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
  };

  logic [7:0] rc_exp [10] = '{
    8'h01,8'h02,8'h04,8'h08,8'h10,8'h20,8'h40,8'h80,8'h1b,8'h36
  };

  localparam logic [127:0] K_FIPS = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] K_ZERO = 128'h0;

  function automatic logic [127:0] key_next(input logic [127:0] k,
                                            input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    w0 = k[127:96];
    w1 = k[95:64];
    w2 = k[63:32];
    w3 = k[31:0];
    t = {sbox[w3[23:16]], sbox[w3[15:8]], sbox[w3[7:0]], sbox[w3[31:24]]};
    t = t ^ {rc, 24'h0};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  // External expansion unit: result valid one cycle after the step.
  always @(posedge clk) begin
    if (exp_step) exp_key_out <= key_next(exp_key_cur, exp_rcon);
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [63:0] wr_q [$];
  int          wc_q [$];
  int          acc_q [$];
  int          done_q [$];
  logic [7:0]  rcon_q [$];
  int          n_busy = 0;

  // Event log sampled mid-cycle.
  always @(negedge clk) begin
    if (en_wr) begin
      wr_q.push_back(ram_in);
      wc_q.push_back(cyc);
    end
    if (key_accept) acc_q.push_back(cyc);
    if (set_done) done_q.push_back(cyc);
    if (exp_step) rcon_q.push_back(exp_rcon);
    if (busy) n_busy = n_busy + 1;
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_mis++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic wait_accept();
    logic seen;
    seen = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (key_accept === 1'b1) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (done_q.size() < n) chk("done_timeout", 0, 1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_fips(input string t, input int b);
    chk({t, "_w1"}, wr_q[b+0], 64'habf7158809cf4f3c);
    chk({t, "_w2"}, wr_q[b+1], 64'h2b7e151628aed2a6);
    chk({t, "_w3"}, wr_q[b+2], 64'h23a339392a6c7605);
    chk({t, "_w4"}, wr_q[b+3], 64'ha0fafe1788542cb1);
    chk({t, "_w21"}, wr_q[b+20], 64'he13f0cc8b6630ca6);
    chk({t, "_w22"}, wr_q[b+21], 64'hd014f9a8c9ee2589);
  endtask

  task automatic start_key(input logic [127:0] k);
    @(posedge clk);
    #1;
    key_in = k;
    key_valid = 1'b1;
  endtask

  task automatic drop_valid();
    @(posedge clk);
    #1;
    key_valid = 1'b0;
  endtask

  int wb, ab, db, rb, bb, bad;

  initial begin
    kill = 1'b1;
    key_in = K_FIPS;
    key_valid = 1'b1;
    wr_idle = 1'b0;
    exp_key_out = '0;

    // Reset values, with a key offered during kill.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_accept", key_accept, 0);
    chk("rst_busy", busy, 0);
    chk("rst_en_wr", en_wr, 0);
    chk("rst_step", exp_step, 0);
    chk("rst_done", set_done, 0);
    chk("rst_ram_in", ram_in, 0);
    chk("rst_key_cur", exp_key_cur, 0);
    chk("rst_rcon", exp_rcon, 8'h01);
    key_valid = 1'b0;

    // FIPS-197 key, timing and round constants.
    @(posedge clk);
    #1;
    kill = 1'b0;
    wb = wr_q.size();
    ab = acc_q.size();
    db = done_q.size();
    rb = rcon_q.size();
    bb = n_busy;
    start_key(K_FIPS);
    wait_accept();
    chk("t1_busy_acc", busy, 1);
    drop_valid();
    wait_done(db + 1);
    chk("t1_nwr", wr_q.size() - wb, 22);
    check_fips("t1", wb);
    chk("t1_wr1_cyc", wc_q[wb] - acc_q[ab], 1);
    chk("t1_wr2_cyc", wc_q[wb+1] - acc_q[ab], 2);
    chk("t1_wr3_cyc", wc_q[wb+2] - acc_q[ab], 5);
    chk("t1_wr22_cyc", wc_q[wb+21] - acc_q[ab], 42);
    chk("t1_done_cyc", done_q[db] - acc_q[ab], 43);
    chk("t1_busy_cnt", n_busy - bb, 44);
    chk("t2_nstep", rcon_q.size() - rb, 10);
    for (int i = 0; i < 10; i++) begin
      chk($sformatf("t2_rcon%0d", i), rcon_q[rb+i], rc_exp[i]);
    end

    // Blocked by wr_idle, then accepted once it drops.
    wb = wr_q.size();
    db = done_q.size();
    @(posedge clk);
    #1;
    key_in = K_FIPS;
    wr_idle = 1'b1;
    key_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk($sformatf("t3_blocked%0d", i), key_accept, 0);
    end
    @(posedge clk);
    #1;
    wr_idle = 1'b0;
    @(negedge clk);
    chk("t3_accept_first", key_accept, 1);
    @(posedge clk);
    #1;
    key_valid = 1'b0;
    wr_idle = 1'b1;
    wait_done(db + 1);
    wr_idle = 1'b0;
    chk("t3_nwr", wr_q.size() - wb, 22);
    check_fips("t3", wb);

    // Back-to-back sets; key_in changes while busy.
    wb = wr_q.size();
    ab = acc_q.size();
    db = done_q.size();
    start_key(K_FIPS);
    wait_accept();
    @(posedge clk);
    #1;
    key_in = K_ZERO;
    wait_accept();
    drop_valid();
    wait_done(db + 2);
    chk("t4_nacc", acc_q.size() - ab, 2);
    chk("t4_acc_gap", acc_q[ab+1] - acc_q[ab], 44);
    chk("t4_done0_cyc", done_q[db] - acc_q[ab], 43);
    chk("t4_nwr", wr_q.size() - wb, 44);
    bad = 0;
    for (int i = wb; i < wr_q.size(); i++) begin
      if (wc_q[i] == acc_q[ab] + 43 || wc_q[i] == acc_q[ab] + 44) bad++;
    end
    chk("t4_boundary_wr", bad, 0);
    check_fips("t6", wb);
    chk("t4_b_w1", wr_q[wb+22], 64'h0);
    chk("t4_b_w3", wr_q[wb+24], 64'h6263636362636363);
    chk("t4_b_w4", wr_q[wb+25], 64'h6263636362636363);
    chk("t4_b_w43", wr_q[wb+42], 64'h23e951cf6f8f188e);
    chk("t4_b_w44", wr_q[wb+43], 64'hb4ef5bcb3e92e211);

    // Kill at cycle 20 of a set, then a fresh set.
    wb = wr_q.size();
    db = done_q.size();
    start_key(K_FIPS);
    wait_accept();
    drop_valid();
    repeat (19) @(posedge clk);
    #1;
    kill = 1'b1;
    @(posedge clk);
    #1;
    kill = 1'b0;
    bad = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (en_wr !== 1'b0 || busy !== 1'b0 || set_done !== 1'b0) bad++;
    end
    chk("t5_quiet", bad, 0);
    chk("t5_nwr", wr_q.size() - wb, 10);
    chk("t5_ndone", done_q.size() - db, 0);
    chk("t5_key_cur", exp_key_cur, 0);
    chk("t5_rcon", exp_rcon, 8'h01);
    wb = wr_q.size();
    start_key(K_ZERO);
    wait_accept();
    drop_valid();
    wait_done(db + 1);
    chk("t5_new_nwr", wr_q.size() - wb, 22);
    chk("t5_new_w1", wr_q[wb], 64'h0);
    chk("t5_new_w4", wr_q[wb+3], 64'h6263636362636363);
    chk("t5_new_w22", wr_q[wb+21], 64'hb4ef5bcb3e92e211);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
